// File: rtl/ifu_pkg.sv
// Shared constants for the instruction fetch unit: INS field layout, type/branch codes,
// the NOP word, flag indices and FSM state encoding.
package ifu_pkg;

    localparam int IFU_INS_W      = 21;
    localparam int IFU_PC_W       = 8;
    localparam int IFU_IMEM_DEPTH = 256;

    localparam int INSTYPE_HI = 20;
    localparam int INSTYPE_LO = 19;
    localparam int IR_BIT     = 18;
    localparam int OP_HI      = 17;
    localparam int OP_LO      = 14;
    localparam int TGT_HI     = 13;
    localparam int TGT_LO     = 11;
    localparam int AMUX_HI    = 10;
    localparam int AMUX_LO    = 8;
    localparam int BMUX_HI    = 7;
    localparam int BMUX_LO    = 5;
    localparam int IMM_HI     = 7;
    localparam int IMM_LO     = 0;

    localparam logic [1:0] INSTYPE_JMP  = 2'b00;
    localparam logic [1:0] INSTYPE_MOV  = 2'b01;
    localparam logic [1:0] INSTYPE_CMP  = 2'b10;
    localparam logic [1:0] INSTYPE_MATH = 2'b11;

    localparam logic [3:0] BR_ALWAYS = 4'b0000;
    localparam logic [3:0] BR_Z      = 4'b0001;
    localparam logic [3:0] BR_NZ     = 4'b0010;
    localparam logic [3:0] BR_C      = 4'b0011;
    localparam logic [3:0] BR_NC     = 4'b0100;
    localparam logic [3:0] BR_N      = 4'b0101;
    localparam logic [3:0] BR_NN     = 4'b0110;
    localparam logic [3:0] BR_V      = 4'b0111;

    // JMP type with OP=1111, which never resolves as taken.
    localparam logic [IFU_INS_W-1:0] NOP = 21'h03C000;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PRIME = 2'b01,
        ST_RUN   = 2'b10
    } state_e;

    function automatic logic br_cond(input logic [3:0] op, input logic [3:0] flags);
        logic hit;
        hit = 1'b0;
        case (op)
            BR_ALWAYS: hit = 1'b1;
            BR_Z:      hit = flags[FLAG_Z];
            BR_NZ:     hit = !flags[FLAG_Z];
            BR_C:      hit = flags[FLAG_C];
            BR_NC:     hit = !flags[FLAG_C];
            BR_N:      hit = flags[FLAG_N];
            BR_NN:     hit = !flags[FLAG_N];
            BR_V:      hit = flags[FLAG_V];
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ifu_imem.sv
// Program memory: one synchronous write port and one registered read port.
module ifu_imem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 21
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: program memory, IDLE/PRIME/RUN sequencer, zero-bubble JMP resolver, retire counter.
// Optional IFU_SELF_JUMP_HALT_EN: an unconditional jump to itself halts the unit and pulses DONE.
module instr_fetch_unit
    import ifu_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 START,
    input  logic                 HALT_REQ,
    input  logic                 LD_VALID,
    output logic                 LD_READY,
    input  logic [IFU_PC_W-1:0]  LD_ADDR,
    input  logic [IFU_INS_W-1:0] LD_DATA,
    input  logic [7:0]           FLAGS,
    input  logic [7:0]           Addr,
    output logic [IFU_INS_W-1:0] INS,
    output logic                 INS_VALID,
    output logic [IFU_PC_W-1:0]  PC,
`ifdef IFU_SELF_JUMP_HALT_EN
    output logic                 DONE,
`endif
    output logic [15:0]          RETIRED
);

    state_e                 state_reg, state_next;
    logic [IFU_PC_W-1:0]    pc_reg;
    logic [IFU_PC_W-1:0]    pc_out_reg;
    logic [IFU_PC_W-1:0]    fetch_addr;
    logic [IFU_PC_W-1:0]    target;
    logic [IFU_INS_W-1:0]   ins_q;
    logic [15:0]            retired_reg;
    logic                   fetch_en;
    logic                   taken;
    logic                   self_jump;
    logic                   load_we;
    logic                   unused_flags;

    assign unused_flags = ^FLAGS[7:4];

    assign LD_READY  = (state_reg == ST_IDLE);
    assign load_we   = LD_VALID && LD_READY;
    assign INS_VALID = (state_reg == ST_RUN);
    assign INS       = INS_VALID ? ins_q : NOP;
    assign PC        = pc_out_reg;
    assign RETIRED   = retired_reg;

    // Resolve the branch on the word being issued so the redirect costs no bubble.
    always_comb begin
        target = ins_q[IR_BIT] ? ins_q[IMM_HI:IMM_LO] : Addr;
        taken  = (state_reg == ST_RUN)
              && (ins_q[INSTYPE_HI:INSTYPE_LO] == INSTYPE_JMP)
              && br_cond(ins_q[OP_HI:OP_LO], FLAGS[3:0]);
`ifdef IFU_SELF_JUMP_HALT_EN
        self_jump = taken && (ins_q[OP_HI:OP_LO] == BR_ALWAYS) && (target == pc_out_reg);
`else
        self_jump = 1'b0;
`endif
    end

    always_comb begin
        state_next = state_reg;
        fetch_en   = 1'b0;
        fetch_addr = pc_reg;
        case (state_reg)
            ST_IDLE: begin
                if (START) begin
                    state_next = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (HALT_REQ) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_RUN;
                    fetch_en   = 1'b1;
                    fetch_addr = '0;
                end
            end
            ST_RUN: begin
                if (HALT_REQ || self_jump) begin
                    state_next = ST_IDLE;
                end else begin
                    fetch_en   = 1'b1;
                    fetch_addr = taken ? target : pc_reg;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= '0;
            pc_out_reg  <= '0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (fetch_en) begin
                pc_out_reg <= fetch_addr;
                pc_reg     <= fetch_addr + 1'b1;
            end
            if ((state_reg == ST_RUN) && (retired_reg != 16'hFFFF)) begin
                retired_reg <= retired_reg + 16'd1;
            end
        end
    end

`ifdef IFU_SELF_JUMP_HALT_EN
    logic done_reg;
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= self_jump;
        end
    end
    assign DONE = done_reg;
`endif

    ifu_imem #(
        .DEPTH (IFU_IMEM_DEPTH),
        .AW    (IFU_PC_W),
        .DW    (IFU_INS_W)
    ) u_imem (
        .clk   (CLK),
        .we    (load_we),
        .waddr (LD_ADDR),
        .wdata (LD_DATA),
        .re    (fetch_en),
        .raddr (fetch_addr),
        .rdata (ins_q)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: load, sequential issue, branches, wrap, halt, async reset.
module tb_instr_fetch_unit;

    logic        CLK;
    logic        RSTn;
    logic        START;
    logic        HALT_REQ;
    logic        LD_VALID;
    logic        LD_READY;
    logic [7:0]  LD_ADDR;
    logic [20:0] LD_DATA;
    logic [7:0]  FLAGS;
    logic [7:0]  Addr;
    logic [20:0] INS;
    logic        INS_VALID;
    logic [7:0]  PC;
    logic [15:0] RETIRED;
`ifdef IFU_SELF_JUMP_HALT_EN
    logic        DONE;
`endif

    int n_checks;
    int n_fails;

    logic [20:0] prog [0:255];
    logic [20:0] nop_word;

    instr_fetch_unit dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .START     (START),
        .HALT_REQ  (HALT_REQ),
        .LD_VALID  (LD_VALID),
        .LD_READY  (LD_READY),
        .LD_ADDR   (LD_ADDR),
        .LD_DATA   (LD_DATA),
        .FLAGS     (FLAGS),
        .Addr      (Addr),
        .INS       (INS),
        .INS_VALID (INS_VALID),
        .PC        (PC),
`ifdef IFU_SELF_JUMP_HALT_EN
        .DONE      (DONE),
`endif
        .RETIRED   (RETIRED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [20:0] d);
        LD_ADDR  = a;
        LD_DATA  = d;
        LD_VALID = 1'b1;
        tick();
        LD_VALID = 1'b0;
        $display("load   mem[%02h] = %06h", a, d);
    endtask

    task automatic expect_issue(input string tag, input logic [7:0] a);
        chk({tag, "_valid"}, {31'd0, INS_VALID}, 32'd1);
        chk({tag, "_pc"}, {24'd0, PC}, {24'd0, a});
        chk({tag, "_ins"}, {11'd0, INS}, {11'd0, prog[a]});
        $display("issue  %s PC=%02h INS=%06h", tag, PC, INS);
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_valid"}, {31'd0, INS_VALID}, 32'd0);
        chk({tag, "_ins"}, {11'd0, INS}, {11'd0, nop_word});
        $display("idle   %s INS=%06h", tag, INS);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        nop_word = 21'h03C000;
        RSTn = 1'b0; START = 1'b0; HALT_REQ = 1'b0; LD_VALID = 1'b0;
        LD_ADDR = '0; LD_DATA = '0; FLAGS = 8'h00; Addr = 8'h10;

        // {INSTYPE, I/R, OP, 6'b0, IMM}
        prog[8'h00] = {2'b01, 1'b1, 4'b0000, 6'd0, 8'h11}; // MOV
        prog[8'h01] = {2'b11, 1'b0, 4'b0010, 6'd0, 8'h22}; // MATH
        prog[8'h02] = {2'b00, 1'b0, 4'b1111, 6'd0, 8'h00}; // JMP never
        prog[8'h03] = {2'b00, 1'b1, 4'b0000, 6'd0, 8'h40}; // JMP always imm 0x40
        prog[8'h40] = {2'b00, 1'b0, 4'b0001, 6'd0, 8'h00}; // JMP Z via Addr
        prog[8'h10] = {2'b01, 1'b0, 4'b0101, 6'd0, 8'h33}; // MOV
        prog[8'h11] = {2'b00, 1'b1, 4'b0000, 6'd0, 8'h40}; // JMP always imm 0x40
        prog[8'h41] = {2'b00, 1'b1, 4'b0000, 6'd0, 8'hFF}; // JMP always imm 0xFF
        prog[8'hFF] = {2'b10, 1'b0, 4'b0011, 6'd0, 8'h44}; // CMP

        tick();
        tick();
        expect_idle("reset");
        chk("reset_pc", {24'd0, PC}, 32'd0);
        chk("reset_retired", {16'd0, RETIRED}, 32'd0);
        chk("reset_ld_ready", {31'd0, LD_READY}, 32'd1);
        RSTn = 1'b1;

        load(8'h00, prog[8'h00]);
        load(8'h01, prog[8'h01]);
        load(8'h02, prog[8'h02]);
        load(8'h03, prog[8'h03]);
        load(8'h40, prog[8'h40]);
        load(8'h10, prog[8'h10]);
        load(8'h11, prog[8'h11]);
        load(8'h41, prog[8'h41]);
        load(8'hFF, prog[8'hFF]);

        START = 1'b1;
        FLAGS = 8'h01;
        tick();
        START = 1'b0;
        expect_idle("prime");
        chk("prime_ld_ready", {31'd0, LD_READY}, 32'd0);

        tick(); expect_issue("seq0", 8'h00);
        tick(); expect_issue("seq1", 8'h01);
        tick(); expect_issue("seq2", 8'h02);
        tick(); expect_issue("seq3", 8'h03);
        chk("retired3", {16'd0, RETIRED}, 32'd3);
        tick(); expect_issue("jmp_imm", 8'h40);
        tick(); expect_issue("jz_taken", 8'h10);
        FLAGS = 8'h00;
        tick(); expect_issue("after_mov", 8'h11);
        tick(); expect_issue("back40", 8'h40);
        tick(); expect_issue("jz_not_taken", 8'h41);
        tick(); expect_issue("to_ff", 8'hFF);
        tick(); expect_issue("wrap", 8'h00);

        // Load attempt while running must be ignored.
        LD_ADDR  = 8'h01;
        LD_DATA  = 21'h1ABCDE;
        LD_VALID = 1'b1;
        tick(); expect_issue("run_load", 8'h01);
        chk("run_ld_ready", {31'd0, LD_READY}, 32'd0);
        HALT_REQ = 1'b1;
        tick();
        HALT_REQ = 1'b0;
        LD_VALID = 1'b0;
        expect_idle("halt");
        chk("halt_ld_ready", {31'd0, LD_READY}, 32'd1);
        chk("halt_pc_hold", {24'd0, PC}, 32'd1);
        chk("halt_retired", {16'd0, RETIRED}, 32'd12);
        tick();
        chk("idle_retired_hold", {16'd0, RETIRED}, 32'd12);

        // Re-run: mem[1] must still hold its original word.
        START = 1'b1;
        tick();
        START = 1'b0;
        expect_idle("rerun_prime");
        tick(); expect_issue("rerun0", 8'h00);
        tick(); expect_issue("rerun1", 8'h01);

        // Asynchronous reset between clock edges.
        #1 RSTn = 1'b0;
        #1;
        expect_idle("async_rst");
        chk("async_rst_pc", {24'd0, PC}, 32'd0);
        chk("async_rst_retired", {16'd0, RETIRED}, 32'd0);
        #2 RSTn = 1'b1;

        START = 1'b1;
        tick();
        START = 1'b0;
        expect_idle("post_rst_prime");
        tick(); expect_issue("post_rst0", 8'h00);
        tick(); expect_issue("post_rst1", 8'h01);
        tick(); expect_issue("post_rst2", 8'h02);
        chk("post_rst_retired", {16'd0, RETIRED}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction supplier for the 8-register CPU core. It drives the 21-bit INS word that the core's decoder consumes.
- Holds a program memory, loaded via a valid/ready port while idle, plus a program counter.
- In RUN it issues one instruction per cycle.
- Resolves JMP-type instructions itself from FLAGS and the core's Addr output, with zero-bubble redirect.

Parameters:
- INS_W, 21, instruction width; fields [20:19] INSTYPE, [18] I/R, [17:14] OP, [13:11] TGT, [10:8] AMUX, [7:5] BMUX, [7:0] IMM.
- PC_W, 8, program counter / memory address width.
- IMEM_DEPTH, 256, program memory words (2**PC_W).

Ports:
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- START  in  1  begin execution at PC 0 (sampled in IDLE only).
- HALT_REQ  in  1  stop execution, return to IDLE.
- LD_VALID  in  1  program-load write request.
- LD_READY  out  1  load accepted; equals (state==IDLE).
- LD_ADDR  in  PC_W  load address.
- LD_DATA  in  INS_W  load word.
- FLAGS  in  8  core flags: [0]=Z, [1]=C, [2]=N, [3]=V.
- Addr  in  8  core register-sourced jump target.
- INS  out  INS_W  instruction to core.
- INS_VALID  out  1  INS is a real program instruction.
- PC  out  PC_W  address of the instruction currently on INS.
- RETIRED  out  16  count of issued valid instructions, saturating at 0xFFFF.

Behaviour:
- NOP constant = 21'h03C000 (JMP type, OP=1111, never taken). INS carries NOP whenever INS_VALID=0.
- Reset (async, any state): state=IDLE, pc=0, PC=0, INS=NOP, INS_VALID=0, RETIRED=0. Memory contents are not reset.
- Memory: synchronous write; registered read into ins_q at the clock edge.
- States:
  - IDLE: LD_VALID && LD_READY writes mem[LD_ADDR] <= LD_DATA. START moves to PRIME with fetch_addr=0. START and a load in the same cycle: both take effect; the write lands before PRIME reads.
  - PRIME (1 cycle): ins_q <= mem[fetch_addr], PC <= fetch_addr, pc <= fetch_addr+1. Then RUN. INS_VALID=0.
  - RUN: INS=ins_q, INS_VALID=1, RETIRED++ each cycle. Next fetch_addr = taken ? target : pc. Then ins_q <= mem[fetch_addr], PC <= fetch_addr, pc <= fetch_addr+1.
- Branch resolution (combinational on INS in RUN, INSTYPE==00):
  - OP conditions: 0000 always; 0001 Z; 0010 !Z; 0011 C; 0100 !C; 0101 N; 0110 !N; 0111 V; others never.
  - target = INS[18] ? INS[7:0] : Addr.
- PC wrap: 255+1 -> 0, silently.
- HALT_REQ in RUN or PRIME: next state IDLE, INS=NOP, INS_VALID=0, PC holds the last issued address, RETIRED holds. HALT_REQ in IDLE: no effect. HALT_REQ and START together in IDLE: START wins.
- START outside IDLE is ignored. LD_VALID outside IDLE is ignored (LD_READY=0, no write).

Optional Feature:
- Macro: IFU_SELF_JUMP_HALT_EN.
- With the macro defined: in RUN, a taken always-condition JMP whose target equals PC returns the unit to IDLE on the next edge, same as HALT_REQ; the jump itself counts as retired. Also adds output DONE, which pulses 1 cycle on that transition.
- Without the macro: a self-jump loops forever and the DONE port is absent.

Decomposition:
- Package ifu_pkg:
  - INS field bit positions.
  - INSTYPE codes (JMP=00, MOV=01, CMP=10, MATH=11).
  - Branch OP condition codes.
  - NOP constant.
  - FLAGS bit indices.
  - State encoding IDLE/PRIME/RUN.
- Sub-module ifu_imem: IMEM_DEPTH x INS_W array with sync write port and registered read port.
- Top-level holds the FSM, PC, branch resolver and counter.

Test Plan:
- Load mem[0..2] = MOV, MATH, NOP-class words; START -> cycle 1 PRIME with INS_VALID=0; cycles 2..4 INS=mem[0..2] with PC=0,1,2; RETIRED=3 after 3 RUN cycles.
- mem[3] = unconditional JMP immediate 8'h40 -> the cycle after INS=mem[3], INS=mem[0x40] and PC=0x40 (no bubble).
- Conditional JMP, OP=0001 register-sourced, Addr=0x10: with FLAGS[0]=1 next PC=0x10; repeat with FLAGS[0]=0 -> next PC=PC+1.
- Instruction at 0xFF is non-branch -> next PC=0x00.
- HALT_REQ mid-run -> next cycle INS=21'h03C000, INS_VALID=0, LD_READY=1. LD_VALID while RUN -> memory unchanged (read back after reload run).
- RSTn low mid-run -> INS=NOP and PC=0 immediately (asynchronous); after release a new START re-executes the previously loaded program unchanged.
